uart_tx_fifo: RTL and testbench

- Memory-mapped-agnostic UART transmit engine that drives the SoC's `uart_tx` pin.
- Accepts bytes over a valid/ready stream from the SoC bus-side UART register decode and buffers them in a FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud rate derived from the system clock.
- It is the stage directly upstream of the pin that the SoC bench's UART monitor samples.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_tx_fifo_if.sv | 18 +
 rtl/uart_sync_fifo.sv | 90 +++++++++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: FSM state encoding, baud divisor helper, frame
// length and the even-parity helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state, 8E1 frame).
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 32'd8;

    localparam logic [2:0] UART_ST_IDLE  = 3'd0;
    localparam logic [2:0] UART_ST_START = 3'd1;
    localparam logic [2:0] UART_ST_DATA  = 3'd2;
    localparam logic [2:0] UART_ST_STOP  = 3'd3;

`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] UART_ST_PARITY = 3'd4;
    localparam int         UART_FRAME_BITS = 32'd11;

    typedef enum logic [2:0] {
        ST_IDLE   = UART_ST_IDLE,
        ST_START  = UART_ST_START,
        ST_DATA   = UART_ST_DATA,
        ST_STOP   = UART_ST_STOP,
        ST_PARITY = UART_ST_PARITY
    } uart_state_e;
`else
    localparam int         UART_FRAME_BITS = 32'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = UART_ST_IDLE,
        ST_START = UART_ST_START,
        ST_DATA  = UART_ST_DATA,
        ST_STOP  = UART_ST_STOP
    } uart_state_e;
`endif

    // Clock cycles per bit period, truncating.
    function automatic int uart_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even parity: XOR of all data bits.
    function automatic logic uart_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte stream handshake into the UART transmitter.
//   in_data  : byte to transmit          (master -> slave)
//   in_valid : in_data valid this cycle  (master -> slave)
//   in_ready : slave can accept a byte   (slave  -> master)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with a first-word-fall-through read side.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i (ignored while full)
//   wdata_i   : write data
//   pop_i     : consume rdata_o (ignored while rvalid_o is low)
//   rdata_o   : head entry
//   rvalid_o  : head entry is presented to the reader
//   full_o    : registered full flag
//   count_o   : number of stored entries
// DEPTH must be a power of two, minimum 2; pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 32'd8,
    parameter int DEPTH = 32'd16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       rvalid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 32'd1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             avail_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    // The read side presents a word one cycle after it lands, so a write into
    // an empty FIFO reaches the consumer on the following cycle. The count
    // check keeps a stale avail_q from underflowing right after a pop.
    assign rvalid_o  = avail_q && (count_q != {CW{1'b0}});
    assign push_ok_s = push_i && !full_q;
    assign pop_ok_s  = pop_i && rvalid_o;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign count_o   = count_q;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(32'd1);
            2'b01:   count_d = count_q - CW'(32'd1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(32'd1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(32'd1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            avail_q <= (count_q != {CW{1'b0}});
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: bytes from a valid/ready stream are queued in a
// FIFO and serialised LSB first as 8N1 (8E1 with UART_TX_PARITY_EN defined).
//   clk, rst   : system clock, asynchronous active-high reset
//   in_if      : byte stream (in_data, in_valid, in_ready), slave side
//   uart_tx    : serial line, idles high, driven from a flop
//   busy       : frame on the line or bytes queued
//   fifo_count : bytes queued, excluding the one being shifted
// Optional feature macro: UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 32'd100000000,
    parameter int BAUD       = 32'd115200,
    parameter int FIFO_DEPTH = 32'd16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               in_if,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int CW           = $clog2(FIFO_DEPTH) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             pop_s;
    logic             bit_done_s;
    logic [7:0]       fifo_rdata_s;
    logic             fifo_rvalid_s;
    logic             fifo_full_s;
    logic [CW-1:0]    fifo_count_s;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (in_if.in_valid),
        .wdata_i  (in_if.in_data),
        .pop_i    (pop_s),
        .rdata_o  (fifo_rdata_s),
        .rvalid_o (fifo_rvalid_s),
        .full_o   (fifo_full_s),
        .count_o  (fifo_count_s)
    );

    assign in_if.in_ready = !fifo_full_s;
    assign fifo_count     = fifo_count_s;
    assign uart_tx        = tx_q;
    assign busy           = (state_q != ST_IDLE) || (fifo_count_s != {CW{1'b0}});
    assign bit_done_s     = (cnt_q == CNT_MAX);

    // Serialiser next state. tx_d follows the state being entered so the line
    // flop changes on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fifo_rvalid_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = uart_even_parity(fifo_rdata_s);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d   = ST_DATA;
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    cnt_d = CNT_ZERO;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                    cnt_d   = CNT_ZERO;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    cnt_d = CNT_ZERO;
                    // Chain straight into the next frame when a byte waits.
                    if (fifo_rvalid_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        state_d = ST_START;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d   = uart_even_parity(fifo_rdata_s);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serialiser state register and line flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo with a fast baud divisor (16 clk/bit).
// A line monitor decodes frames independently and a scoreboard queue of
// accepted bytes supplies the expected data.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DEPTH    = 16;
    localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    localparam int FRAME    = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_tx;
    logic       busy;
    logic [4:0] fifo_count;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: bytes accepted by the handshake, in order.
    logic [7:0] exp_q[$];
    int         rst_cnt = 0;
    int         n_frames = 0;
    int         frame_starts[$];

    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end

    // in_ready must be low exactly when the FIFO holds DEPTH bytes.
    always @(negedge clk) begin
        if (!rst) check_val("ready_vs_count", int'(bus.in_ready), int'(fifo_count != 5'(DEPTH)));
    end

    // Line monitor: find the start edge, sample at bit centres.
    int         m_t0, m_rs;
    logic [7:0] m_d, m_e;
    logic       m_st, m_sb, m_p;
    initial begin
        m_p = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst && uart_tx === 1'b0) begin
                m_t0 = cyc;
                m_rs = rst_cnt;
                frame_starts.push_back(m_t0);
                repeat (CPB / 2) @(posedge clk);
                #1 m_st = uart_tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(posedge clk);
                    #1 m_d[k] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(posedge clk);
                #1 m_p = uart_tx;
`endif
                repeat (CPB) @(posedge clk);
                #1 m_sb = uart_tx;
                if (m_rs == rst_cnt) begin
                    check_val("start_bit", int'(m_st), 0);
                    check_val("stop_bit", int'(m_sb), 1);
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_frame", int'(m_d), -1);
                    end else begin
                        m_e = exp_q.pop_front();
                        check_val("frame_data", int'(m_d), int'(m_e));
`ifdef UART_TX_PARITY_EN
                        check_val("parity_bit", int'(m_p), int'(^m_e));
`endif
                    end
                    n_frames++;
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Present a byte and hold it until accepted; returns cycles spent waiting.
    task automatic send_byte(input logic [7:0] b, output int waited);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 40 * FRAME) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 40 * FRAME) check_val("timeout_ready", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_starts(input int n, input string tag);
        int g = 0;
        while (frame_starts.size() < n && g < 4 * FRAME) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 4 * FRAME) check_val(tag, 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < 40 * FRAME) begin
            @(posedge clk); #1;
            g++;
        end
        check_val(tag, int'(g < 40 * FRAME), 1);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    int         w, acc, t0, nf, lows, blocked_idx, nstart;
    logic [7:0] bytes[18];
    logic [7:0] rnd[14];

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_uart_tx", int'(uart_tx), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_in_ready", int'(bus.in_ready), 1);
        check_val("rst_fifo_count", int'(fifo_count), 0);
        rst = 1'b0;

        // Idle line after reset.
        lows = 0;
        repeat (20000) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1 || fifo_count !== 5'd0) lows++;
        end
        check_val("idle_bad_samples", lows, 0);

        // Single byte: latency, frame length, busy.
        send_byte(8'h41, w);
        bus.in_valid = 1'b0;
        acc = cyc;
        wait_starts(1, "timeout_start_41");
        t0 = frame_starts[0];
        check_val("start_latency", t0 - acc, 2);
        nf = n_frames;
        wait_cyc(t0 + FRAME - 1);
        check_val("frame_41_decoded", n_frames, nf + 1);
        check_val("busy_last_stop_cycle", int'(busy), 1);
        wait_cyc(t0 + FRAME);
        check_val("line_high_after_frame", int'(uart_tx), 1);
        check_val("busy_after_frame", int'(busy), 0);
        wait_drain("drain_41");

        // Three consecutive writes, contiguous frames.
        nstart = frame_starts.size();
        send_byte(8'h48, w);
        check_val("count_after_w1", int'(fifo_count), 1);
        send_byte(8'h69, w);
        check_val("count_after_w2", int'(fifo_count), 2);
        send_byte(8'h0A, w);
        check_val("count_after_w3", int'(fifo_count), 2);
        bus.in_valid = 1'b0;
        wait_drain("drain_hi");
        check_val("hi_frames", frame_starts.size() - nstart, 3);
        check_val("hi_total_span", frame_starts[nstart + 2] + FRAME - frame_starts[nstart], 3 * FRAME);

        // Overfill: 18 bytes back to back with in_valid held.
        nstart = frame_starts.size();
        blocked_idx = -1;
        for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 18; i++) begin
            send_byte(bytes[i], w);
            if (w != 0 && blocked_idx < 0) blocked_idx = i;
        end
        bus.in_valid = 1'b0;
        check_val("first_blocked_byte", blocked_idx, 17);
        wait_drain("drain_burst");
        check_val("burst_frames", frame_starts.size() - nstart, 18);
        check_val("burst_contiguous", frame_starts[nstart + 17] - frame_starts[nstart], 17 * FRAME);

        // Reset in the middle of bit 4 of 0x55 with three bytes queued.
        nstart = frame_starts.size();
        send_byte(8'h55, w);
        send_byte(8'h11, w);
        send_byte(8'h22, w);
        send_byte(8'h33, w);
        bus.in_valid = 1'b0;
        check_val("queued_before_rst", int'(fifo_count), 3);
        wait_starts(nstart + 1, "timeout_start_55");
        t0 = frame_starts[nstart];
        wait_cyc(t0 + 5 * CPB + CPB / 2);
        check_val("bit4_of_55", int'(uart_tx), 1);
        rst_cnt++;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_val("async_rst_uart_tx", int'(uart_tx), 1);
        check_val("async_rst_count", int'(fifo_count), 0);
        check_val("async_rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lows = 0;
        repeat (3 * FRAME) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        check_val("post_rst_line_low", lows, 0);
        check_val("post_rst_no_frames", frame_starts.size(), nstart + 1);
        nf = n_frames;
        send_byte(8'hA5, w);
        bus.in_valid = 1'b0;
        wait_drain("drain_a5");
        check_val("a5_frames", n_frames, nf + 1);

        // Random bytes with random gaps.
        nf = n_frames;
        rnd[0] = 8'h07;
        rnd[1] = 8'h03;
        for (int i = 2; i < 14; i++) rnd[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2 * FRAME)) @(posedge clk);
            #1;
            send_byte(rnd[i], w);
        end
        bus.in_valid = 1'b0;
        wait_drain("drain_random");
        check_val("random_frames", n_frames - nf, 14);
        check_val("final_count", int'(fifo_count), 0);
        check_val("final_line", int'(uart_tx), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
